// File: rtl/timer_reader.sv
// Consumer side of the t_en/t_valid/t_out producer handshake: one request at a time,
// words buffered in a show-ahead FIFO. Optional unsolicited-valid counter: TIMER_READER_STRAY_CNT_EN.
module timer_reader #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15,
    parameter int GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        t_en,
    input  logic        t_valid,
    input  logic [15:0] t_out,
    output logic [15:0] d_out,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [4:0]  fill,
    output logic [15:0] words_rx,
    output logic        err_timeout,
    input  logic        clr_err,
    output logic [7:0]  stray_cnt
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_L  = 5'(DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0]  GAP_L    = 8'(GAP);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t         r_state, w_next;
    logic [7:0]     r_tcnt;
    logic [7:0]     r_gap;
    logic [15:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [4:0]     r_count;
    logic [15:0]    r_words;
    logic           r_err;
    logic           w_cap, w_tmo, w_pop;

    assign w_cap = (r_state != IDLE) && t_valid;
    assign w_tmo = (r_state == HOLD) && !t_valid && (r_tcnt == TMO_LAST);
    assign w_pop = d_valid && d_ready;

    always_comb begin
        w_next = r_state;
        t_en   = 1'b0;
        case (r_state)
            IDLE: if (run && r_gap == 8'd0 && r_count < DEPTH_L) w_next = REQ;
            REQ: begin
                t_en   = 1'b1;
                w_next = t_valid ? IDLE : HOLD;
            end
            HOLD: begin
                t_en = 1'b1;
                if (t_valid || w_tmo) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
            r_gap   <= '0;
            r_err   <= 1'b0;
            r_words <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == REQ)
                r_tcnt <= '0;
            else if (r_state == HOLD && !t_valid)
                r_tcnt <= r_tcnt + 8'd1;
            // Gap restarts on both capture and timeout; it only drains while idle.
            if (w_cap || w_tmo)
                r_gap <= GAP_L;
            else if (r_state == IDLE && r_gap != 8'd0)
                r_gap <= r_gap - 8'd1;
            if (w_tmo)
                r_err <= 1'b1;
            else if (clr_err)
                r_err <= 1'b0;
            if (w_cap)
                r_words <= r_words + 16'd1;
        end
    end

    // Storage needs no reset; d_out is masked while empty.
    always_ff @(posedge clk) begin
        if (w_cap) r_mem[r_wp] <= t_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_cap) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            case ({w_cap, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign d_valid     = (r_count != 5'd0);
    assign d_out       = d_valid ? r_mem[r_rp] : 16'd0;
    assign fill        = r_count;
    assign words_rx    = r_words;
    assign err_timeout = r_err;

`ifdef TIMER_READER_STRAY_CNT_EN
    logic [7:0] r_stray;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stray <= '0;
        else if (r_state == IDLE && t_valid && r_stray != 8'hFF)
            r_stray <= r_stray + 8'd1;
    end
    assign stray_cnt = r_stray;
`else
    assign stray_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_timer_reader.sv
// Randomized bench for timer_reader with a transaction-level reference model and directed scenarios.
module tb_timer_reader;
    localparam int DEPTH = 8, TIMEOUT = 15, GAP = 2;
`ifdef TIMER_READER_STRAY_CNT_EN
    localparam bit STRAY = 1'b1;
`else
    localparam bit STRAY = 1'b0;
`endif

    logic clk = 0, rst = 0, run = 0, t_valid = 0, d_ready = 0, clr_err = 0;
    logic [15:0] t_out = '0;
    logic t_en, d_valid, err_timeout;
    logic [15:0] d_out, words_rx;
    logic [4:0] fill;
    logic [7:0] stray_cnt;

    timer_reader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .run(run), .t_en(t_en), .t_valid(t_valid), .t_out(t_out),
        .d_out(d_out), .d_valid(d_valid), .d_ready(d_ready), .fill(fill), .words_rx(words_rx),
        .err_timeout(err_timeout), .clr_err(clr_err), .stray_cnt(stray_cnt));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding request tracked by its age, idle time since the last one ended.
    int          m_q[$];
    bit          m_act = 0;
    int          m_age = 0, m_idle = GAP, m_stray = 0;
    logic [15:0] m_words = 0;
    bit          m_err = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete(); m_act = 0; m_age = 0; m_idle = GAP; m_stray = 0; m_words = 0; m_err = 0;
        end else begin
            int sz;
            bit pop, cap, tmo;
            sz = m_q.size();
            pop = (sz > 0) && d_ready;
            cap = 0; tmo = 0;
            if (m_act) begin
                if (t_valid) cap = 1;
                else if (m_age == TIMEOUT) tmo = 1;
                else m_age++;
                if (cap || tmo) begin m_act = 0; m_idle = 0; end
            end else begin
                if (t_valid && STRAY && m_stray < 255) m_stray++;
                if (run && m_idle >= GAP && sz < DEPTH) begin m_act = 1; m_age = 0; end
                else if (m_idle < GAP) m_idle++;
            end
            if (tmo) m_err = 1;
            else if (clr_err) m_err = 0;
            if (pop) void'(m_q.pop_front());
            if (cap) begin m_q.push_back(int'(t_out)); m_words = m_words + 16'd1; end
        end
    end

    always @(negedge clk) begin
        chk("t_en", t_en, m_act);
        chk("d_valid", d_valid, m_q.size() != 0);
        chk("d_out", d_out, m_q.size() != 0 ? m_q[0] : 0);
        chk("fill", fill, m_q.size());
        chk("words_rx", words_rx, m_words);
        chk("err_timeout", err_timeout, m_err);
        chk("stray_cnt", stray_cnt, m_stray);
    end

    // Producer: answers after a random latency, never, chaotically, or on demand.
    int pmode = 1, plat_min = 0, plat_max = 0, pcnt = 0, plat = 0;
    logic stray_pulse = 0;
    int pdata[$];
    task automatic pdrive();
        t_valid = 1;
        if (pdata.size() > 0) t_out = 16'(pdata.pop_front());
        else t_out = 16'($urandom);
    endtask
    always @(posedge clk) begin
        #2;
        t_valid = 0;
        t_out = 'x;
        case (pmode)
            0: if (!t_en) begin
                   pcnt = 0;
                   plat = plat_min + int'($urandom % (plat_max - plat_min + 1));
               end else begin
                   if (pcnt == plat) pdrive();
                   pcnt++;
               end
            2: if ($urandom % 4 == 0) pdrive();
            3: if (stray_pulse) pdrive();
            default: ;
        endcase
    end

    // t_en run-length monitor.
    int gaps[$], highs[$], rises = 0, lowcnt = 0, highcnt = 0;
    bit en_prev = 0, have_low = 0;
    int popped[$];
    always @(negedge clk) begin
        if (t_en) begin
            if (!en_prev) begin rises++; if (have_low) gaps.push_back(lowcnt); highcnt = 0; end
            highcnt++;
        end else begin
            if (en_prev) begin highs.push_back(highcnt); lowcnt = 0; have_low = 1; end
            lowcnt++;
        end
        en_prev = t_en;
    end
    always @(posedge clk) if (rst && d_valid && d_ready) popped.push_back(int'(d_out));

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int r0;
        cyc(2);
        chk("reset fill", fill, 0);
        chk("reset t_en", t_en, 0);
        chk("reset d_out", d_out, 0);
        rst = 1;
        cyc(1);

        // Capture and drain with a 3-cycle producer.
        gaps.delete(); highs.delete(); have_low = 0; popped.delete();
        pmode = 0; plat_min = 3; plat_max = 3; pdata = '{16'h1234, 16'h0042};
        d_ready = 1; run = 1;
        for (int i = 0; i < 100 && words_rx != 2; i++) cyc();
        run = 0;
        cyc(4);
        chk("drain count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("drain word0", popped[0], 32'h1234);
            chk("drain word1", popped[1], 32'h0042);
        end
        chk("drain words_rx", words_rx, 2);
        chk("first t_en high len", highs.size() > 0 ? highs[0] : -1, 4);
        chk("gap between reqs", gaps.size() > 0 ? gaps[0] : -1, GAP + 1);

        // Back-pressure until full.
        d_ready = 0; plat_min = 0; plat_max = 4; run = 1;
        for (int i = 0; i < 500 && fill != 5'(DEPTH); i++) cyc();
        cyc(20);
        chk("bp fill", fill, DEPTH);
        chk("bp t_en", t_en, 0);
        chk("bp words_rx", words_rx, 2 + DEPTH);
        r0 = rises;
        d_ready = 1; cyc(); d_ready = 0;
        chk("bp fill after pop", fill, DEPTH - 1);
        cyc(40);
        chk("bp one new request", rises - r0, 1);
        chk("bp refill", fill, DEPTH);
        chk("bp words_rx after", words_rx, 3 + DEPTH);

        // Timeout and retry.
        highs.delete(); gaps.delete(); have_low = 0;
        pmode = 1; d_ready = 1;
        for (int i = 0; i < 100 && !err_timeout; i++) cyc();
        chk("tmo err set", err_timeout, 1);
        cyc(2);
        chk("tmo t_en high len", highs.size() > 0 ? highs[0] : -1, TIMEOUT + 1);
        r0 = rises;
        for (int i = 0; i < 20 && rises == r0; i++) cyc();
        chk("tmo retry gap", gaps.size() > 0 ? gaps[0] : -1, GAP + 1);
        run = 0;
        clr_err = 1; cyc(); clr_err = 0;
        chk("tmo clr_err", err_timeout, 0);
        for (int i = 0; i < 40 && t_en; i++) cyc();
        chk("tmo retry ended", t_en, 0);
        clr_err = 1; cyc(); clr_err = 0;

        // Simultaneous push and pop at fill=4.
        d_ready = 0; pmode = 0; plat_min = 0; plat_max = 2; run = 1;
        for (int i = 0; i < 200 && fill != 5'd4; i++) cyc();
        run = 0;
        cyc(5);
        chk("pp fill before", fill, 4);
        plat_min = 0; plat_max = 0; run = 1;
        for (int i = 0; i < 20 && !t_en; i++) cyc();
        d_ready = 1; run = 0;
        cyc();
        d_ready = 0;
        chk("pp fill after", fill, 4);
        cyc(4);

        // Reset in the middle of a request.
        d_ready = 1; cyc(); d_ready = 0;
        pmode = 1; run = 1;
        for (int i = 0; i < 20 && !t_en; i++) cyc();
        cyc(3);
        chk("rst pre fill", fill, 3);
        chk("rst pre t_en", t_en, 1);
        #2 rst = 0;
        #1;
        chk("rst async t_en", t_en, 0);
        chk("rst async d_valid", d_valid, 0);
        chk("rst async fill", fill, 0);
        chk("rst async words_rx", words_rx, 0);
        run = 0;
        cyc(2);
        rst = 1;
        cyc(1);

        // Unsolicited valids while idle.
        pmode = 3;
        for (int i = 0; i < 10; i++) begin stray_pulse = (i % 2 == 0); cyc(); end
        stray_pulse = 0;
        cyc(2);
        chk("stray count", stray_cnt, STRAY ? 5 : 0);
        chk("stray fill", fill, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                pmode = int'($urandom % 3);
                plat_min = 0;
                plat_max = int'($urandom_range(0, 20));
            end
            run = ($urandom % 4) != 0;
            d_ready = ($urandom % 2) != 0;
            clr_err = ($urandom % 20) == 0;
            cyc();
        end
        run = 0; d_ready = 0; clr_err = 0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timer_reader.md
Name: timer_reader

Overview:
- Consumer end of the timer producer interface (`t_en` / `t_valid` / `t_out`).
- Requests one value at a time from a producer, captures each valid word into an internal FIFO, and presents the words downstream on a valid/ready port.
- Guards against a producer that never answers with a timeout, and retries after a fixed gap.
- Sits between a value generator (timer or similar) and the display or serializer logic.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of 2, range 2..16.
- TIMEOUT, 15: cycles `t_en` may stay high without `t_valid` before the request is aborted; range 1..255.
- GAP, 2: idle cycles after a capture or a timeout before the next request; 0 allowed.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `run`  in  1  1 = keep requesting values while FIFO has space
- `t_en`  out  1  request to producer
- `t_valid`  in  1  producer word valid
- `t_out`  in  16  producer word
- `d_out`  out  16  FIFO head word
- `d_valid`  out  1  FIFO not empty
- `d_ready`  in  1  downstream accepts head
- `fill`  out  5  FIFO occupancy, 0..DEPTH
- `words_rx`  out  16  captured-word counter, wraps at 16 bits
- `err_timeout`  out  1  sticky timeout flag
- `clr_err`  in  1  clears `err_timeout`
- `stray_cnt`  out  8  unsolicited-valid counter (see Optional Feature)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While `rst`=0:
  - state=IDLE; `t_en`=0; FIFO empty, so `d_valid`=0 and `fill`=0.
  - `d_out`=0; `words_rx`=0; `err_timeout`=0; `stray_cnt`=0; gap and timeout counters=0.
- FSM states: IDLE, REQ, HOLD.
  - IDLE → REQ when `run`=1, gap counter=0 and `fill`<DEPTH.
  - REQ: `t_en`=1; timeout counter loads 0.
  - REQ → HOLD on the next clock; `t_en` stays 1 in HOLD.
  - HOLD, `t_valid`=1: capture `t_out` into FIFO at that edge; `words_rx`+1; `t_en`=0 from the next cycle; gap counter loads GAP; → IDLE.
  - HOLD, `t_valid`=0: timeout counter +1. When it reaches TIMEOUT: `t_en`=0; `err_timeout`=1; gap counter loads GAP; → IDLE.
  - `t_valid`=1 while in REQ is captured exactly as in HOLD (0-cycle producer).
- Gap counter: decrements to 0 in IDLE only.
- `run` dropping to 0 in REQ or HOLD does not abort; the outstanding request completes or times out.
- Only one request is outstanding at a time. A request is issued only when `fill`<DEPTH, so a capture never meets a full FIFO. No overflow path exists.
- FIFO:
  - Show-ahead: `d_valid`=(`fill`≠0); `d_out`=head entry, or 0 when empty.
  - Pop when `d_valid` & `d_ready`.
  - Simultaneous push and pop: `fill` unchanged; ordering preserved.
  - Latency: `t_valid` sampled at edge N → word visible on `d_out` and `d_valid`=1 after edge N when the FIFO was empty.
  - Pointers wrap modulo DEPTH.
- `t_valid`=1 in IDLE is ignored for data (see Optional Feature).
- `err_timeout`: set has priority over `clr_err` in the same cycle.
- `words_rx`: 16-bit wrap, 0xFFFF → 0x0000.
- `t_out` is only sampled when `t_valid`=1; an X on `t_out` otherwise must not propagate.

Optional Feature:
- Macro: `TIMER_READER_STRAY_CNT_EN`.
- Defined: `stray_cnt` increments on every cycle with `t_valid`=1 while state=IDLE, saturating at 255. Cleared only by reset.
- Undefined: no counter logic is built; `stray_cnt` is tied to 0. Port list is identical in both builds.

Test Plan:
- Capture and drain: `run`=1, producer answers 3 cycles after `t_en` rises with 0x1234 then 0x0042, GAP=2, `d_ready`=1 → `d_out` shows 0x1234 then 0x0042 in order. `words_rx`=2; `t_en` low ≥2 cycles between requests.
- Back-pressure: `d_ready`=0, producer always answers → exactly 8 captures; `fill`=8; `t_en` stays 0. Pulse `d_ready` for 1 cycle → `fill`=7, and exactly one new request follows.
- Timeout: producer never answers, TIMEOUT=15 → `t_en` high for exactly 15 HOLD cycles, then 0. `err_timeout`=1; retry after GAP. `clr_err` pulse → 0.
- Simultaneous push and pop at `fill`=4 → `fill` stays 4; data order intact.
- Reset mid-request: `rst`=0 while in HOLD with `fill`=3 → `t_en`, `d_valid`, `fill` and `words_rx` go to 0 immediately, without waiting for a clock edge.
- With the macro defined: 5 unsolicited `t_valid` pulses in IDLE → `stray_cnt`=5 and FIFO unchanged. Without the macro: `stray_cnt`=0.
